// File: rtl/wb_ram_slave.sv
// Wishbone slave RAM with byte enables, configurable response latency,
// out-of-range error termination and abort when the master drops cyc.
module wb_ram_slave #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 0
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic [AW-1:0]   wbs_adr_i,
  input  logic            wbs_we_i,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  output logic [DW-1:0]   wbs_dat_o,
  output logic            wbs_ack_o,
  output logic            wbs_err_o
);

  localparam int SW = DW / 8;
  localparam int BW = (SW > 1) ? $clog2(SW) : 0;
  localparam int IW = $clog2(DEPTH);

  // Handshake: a request is cyc&stb sampled on a rising edge while IDLE;
  // exactly one of ack/err pulses for one cycle per accepted request, unless
  // cyc falls during WAIT, in which case the request is silently dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dat_o_q;

  logic [IW-1:0]   idx_q;
  logic            we_q;
  logic [DW-1:0]   dat_q;
  logic [SW-1:0]   sel_q;
  logic            oor_q;

  logic            req;
  logic [IW-1:0]   live_idx;
  logic            live_oor;
  logic            capture;
  logic            commit;

  logic [IW-1:0]   c_idx;
  logic            c_we;
  logic [DW-1:0]   c_dat;
  logic [SW-1:0]   c_sel;
  logic            c_oor;
  logic            ram_we;
  logic            rd_load;

  logic [DW-1:0]   mem [DEPTH];

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign live_idx = wbs_adr_i[IW+BW-1:BW];
  assign live_oor = |(wbs_adr_i >> (IW + BW));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the commit edge is also the capture edge, so the
  // commit path must take the live bus fields instead of the captured copy.
  always_comb begin
    c_idx = idx_q;
    c_we  = we_q;
    c_dat = dat_q;
    c_sel = sel_q;
    c_oor = oor_q;
    if (state_q == IDLE) begin
      c_idx = live_idx;
      c_we  = wbs_we_i;
      c_dat = wbs_dat_i;
      c_sel = wbs_sel_i;
      c_oor = live_oor;
    end
  end

  assign ram_we  = commit &  c_we & ~c_oor;
  assign rd_load = commit & ~c_we & ~c_oor;
  assign ack_d   = commit & ~c_oor;
  assign err_d   = commit &  c_oor;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_o_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (rd_load) dat_o_q <= mem[c_idx];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (capture) begin
      idx_q <= live_idx;
      we_q  <= wbs_we_i;
      dat_q <= wbs_dat_i;
      sel_q <= wbs_sel_i;
      oor_q <= live_oor;
    end
  end

  // RAM array is deliberately unreset so it maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (ram_we) begin
      for (int b = 0; b < SW; b++) begin
        if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
      end
    end
  end

  assign wbs_dat_o = dat_o_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: instance 0 has no wait states, instance 1
// has three; both share clock and reset.
module tb_wb_ram_slave;

  logic        clk;
  logic        rst_n;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel  [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        err  [2];

  int n_assert = 0;
  int n_fail   = 0;

  wb_ram_slave #(.DW(32), .AW(32), .DEPTH(512), .WAIT_STATES(0)) u_dut0 (
    .sys_clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_adr_i(adr[0]),
    .wbs_we_i(we[0]), .wbs_dat_i(wdat[0]), .wbs_sel_i(sel[0]),
    .wbs_dat_o(rdat[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0])
  );

  wb_ram_slave #(.DW(32), .AW(32), .DEPTH(512), .WAIT_STATES(3)) u_dut1 (
    .sys_clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_adr_i(adr[1]),
    .wbs_we_i(we[1]), .wbs_dat_i(wdat[1]), .wbs_sel_i(sel[1]),
    .wbs_dat_o(rdat[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drop(input int d);
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
    we[d]  = 1'b0;
  endtask

  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] v, input logic [3:0] s,
                      output int lat, output logic got_ack, output logic got_err);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = v; sel[d] = s;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        lat = k; got_ack = ack[d]; got_err = err[d];
        break;
      end
    end
    drop(d);
  endtask

  task automatic b2b(input int d, input logic [31:0] a, output int first, output int gap1,
                     output int gap2);
    int n;
    int t_prev;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = a; sel[d] = 4'hF;
    n = 0; t_prev = 0; first = 0; gap1 = 0; gap2 = 0;
    for (int k = 1; k <= 60 && n < 3; k++) begin
      @(negedge clk);
      if (ack[d]) begin
        if (n == 0) first = k;
        if (n == 1) gap1 = k - t_prev;
        if (n == 2) gap2 = k - t_prev;
        t_prev = k;
        n++;
      end
    end
    drop(d);
  endtask

  initial begin
    int   lat, first, g1, g2;
    logic a, e, seen;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drop(d); adr[d] = '0; wdat[d] = '0; sel[d] = '0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ack%0d", d), 32'(ack[d]), 32'd0);
      chk($sformatf("reset_err%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("reset_dat%0d", d), rdat[d], 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Zero wait states: basic write then read-back.
    xfer(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, lat, a, e);
    chk("ws0_wr_lat", 32'(lat), 32'd1);
    chk("ws0_wr_ack", 32'({a, e}), 32'b10);
    @(negedge clk);
    chk("ws0_ack_pulse", 32'(ack[0]), 32'd0);
    xfer(0, 1'b0, 32'h010, 32'h0, 4'hF, lat, a, e);
    chk("ws0_rd_lat", 32'(lat), 32'd1);
    chk("ws0_rd_ack", 32'({a, e}), 32'b10);
    chk("ws0_rd_dat", rdat[0], 32'hDEADBEEF);

    // Byte enables merge onto the existing word.
    xfer(0, 1'b1, 32'h020, 32'hDEADBEEF, 4'hF, lat, a, e);
    xfer(0, 1'b1, 32'h020, 32'h11223344, 4'h5, lat, a, e);
    chk("sel5_ack", 32'({a, e}), 32'b10);
    xfer(0, 1'b0, 32'h020, 32'h0, 4'hF, lat, a, e);
    chk("sel5_dat", rdat[0], 32'hDE22BE44);

    // Out-of-range accesses: err only, no write, dat_o held.
    xfer(0, 1'b1, 32'h000, 32'hA5A5A5A5, 4'hF, lat, a, e);
    xfer(0, 1'b0, 32'h800, 32'h0, 4'hF, lat, a, e);
    chk("oor_rd_resp", 32'({a, e}), 32'b01);
    chk("oor_rd_lat", 32'(lat), 32'd1);
    chk("oor_rd_hold", rdat[0], 32'hDE22BE44);
    xfer(0, 1'b1, 32'h800, 32'h12345678, 4'hF, lat, a, e);
    chk("oor_wr_resp", 32'({a, e}), 32'b01);
    xfer(0, 1'b0, 32'h000, 32'h0, 4'hF, lat, a, e);
    chk("oor_wr_noalias", rdat[0], 32'hA5A5A5A5);

    // sel=0: write is a no-op with ack, read still returns the full word.
    xfer(0, 1'b1, 32'h020, 32'hFFFFFFFF, 4'h0, lat, a, e);
    chk("sel0_wr_ack", 32'({a, e}), 32'b10);
    xfer(0, 1'b0, 32'h020, 32'h0, 4'hF, lat, a, e);
    chk("sel0_wr_nochg", rdat[0], 32'hDE22BE44);
    xfer(0, 1'b0, 32'h010, 32'h0, 4'h0, lat, a, e);
    chk("sel0_rd_dat", rdat[0], 32'hDEADBEEF);

    b2b(0, 32'h010, first, g1, g2);
    chk("ws0_b2b_first", 32'(first), 32'd1);
    chk("ws0_b2b_gap1", 32'(g1), 32'd2);
    chk("ws0_b2b_gap2", 32'(g2), 32'd2);

    // Three wait states.
    xfer(1, 1'b1, 32'h040, 32'h0BADC0DE, 4'hF, lat, a, e);
    chk("ws3_wr_lat", 32'(lat), 32'd4);
    xfer(1, 1'b0, 32'h040, 32'h0, 4'hF, lat, a, e);
    chk("ws3_rd_lat", 32'(lat), 32'd4);
    chk("ws3_rd_ack", 32'({a, e}), 32'b10);
    chk("ws3_rd_dat", rdat[1], 32'h0BADC0DE);

    b2b(1, 32'h040, first, g1, g2);
    chk("ws3_b2b_first", 32'(first), 32'd4);
    chk("ws3_b2b_gap1", 32'(g1), 32'd5);
    chk("ws3_b2b_gap2", 32'(g2), 32'd5);

    // Abort: cyc dropped one cycle into WAIT.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h040;
    wdat[1] = 32'hCAFEF00D; sel[1] = 4'hF;
    @(negedge clk);
    drop(1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | ack[1] | err[1];
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    xfer(1, 1'b0, 32'h040, 32'h0, 4'hF, lat, a, e);
    chk("abort_no_write", rdat[1], 32'h0BADC0DE);

    // Reset asserted while a request sits in WAIT.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h040; sel[1] = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    drop(1);
    #1;
    chk("midrst_dat1", rdat[1], 32'd0);
    chk("midrst_ack1", 32'(ack[1]), 32'd0);
    chk("midrst_err1", 32'(err[1]), 32'd0);
    chk("midrst_dat0", rdat[0], 32'd0);
    @(negedge clk); rst_n = 1'b1;
    xfer(1, 1'b0, 32'h040, 32'h0, 4'hF, lat, a, e);
    chk("postrst_lat1", 32'(lat), 32'd4);
    chk("postrst_dat1", rdat[1], 32'h0BADC0DE);
    xfer(0, 1'b0, 32'h010, 32'h0, 4'hF, lat, a, e);
    chk("postrst_dat0", rdat[0], 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
